// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch/data) arbiter for one synchronous memory port
// Each transaction runs IDLE -> ACCESS -> RESP; requests are only looked at in IDLE.
module mem_port_arbiter #(
   parameter int WIDTH         = 16,
   parameter bit DATA_PRIORITY = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             f_req,
   input  logic             f_we,
   input  logic [WIDTH-1:0] f_addr,
   input  logic [WIDTH-1:0] f_wdata,
   output logic             f_gnt,
   output logic             f_done,
   output logic [WIDTH-1:0] f_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic             d_gnt,
   output logic             d_done,
   output logic [WIDTH-1:0] d_rdata,
   output logic             mem_en,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             owner_q, owner_d;   // 1 = data requester owns the transaction
   logic             last_q, last_d;     // 1 = data requester was served last
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             we_q, we_d;
   logic             win_d;
   logic             in_access, in_resp, rd_resp;

   // Data wins when alone, or on conflict when prioritised or when fetch went last.
   always_comb begin
      win_d = d_req & (~f_req | (DATA_PRIORITY ? 1'b1 : ~last_q));
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      case (state_q)
         IDLE: begin
            if (f_req | d_req) begin
               state_d = ACCESS;
               owner_d = win_d;
               if (!DATA_PRIORITY) last_d = win_d;
               addr_d  = win_d ? d_addr  : f_addr;
               wdata_d = win_d ? d_wdata : f_wdata;
               we_d    = win_d ? d_we    : f_we;
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   // Reset forces every output low even while the registers still hold a live state.
   always_comb begin
      in_access = ~reset & (state_q == ACCESS);
      in_resp   = ~reset & (state_q == RESP);
      rd_resp   = in_resp & ~we_q;
      mem_en    = in_access;
      mem_we    = in_access & we_q;
      mem_addr  = in_access ? addr_q  : '0;
      mem_wdata = in_access ? wdata_q : '0;
      f_gnt     = in_access & ~owner_q;
      d_gnt     = in_access & owner_q;
      f_done    = in_resp & ~owner_q;
      d_done    = in_resp & owner_q;
      f_rdata   = (rd_resp & ~owner_q) ? mem_rdata : '0;
      d_rdata   = (rd_resp & owner_q)  ? mem_rdata : '0;
   end

endmodule
